freq_meas_ctrl: RTL and testbench
=================================

Name: freq_meas_ctrl

Overview:
Measurement sequencer for the equal-precision frequency gate.
- Issues a measurement reset pulse to the gate and watches its actual-gate output.
- Captures the standard and unknown counts when the gate closes.
- Detects a missing or stalled input signal by timeout.
- Presents each result on a valid/ready interface to the downstream frequency calculator.
- Supports single-shot and continuous (auto re-arm) operation.

Parameters:
- RST_CYCLES, 4: width of the gate_rst pulse in clk_100M cycles; must be ≥1.
- TIMEOUT_CYCLES, 300_000_000: maximum cycles from arm release to gate close (3 s); must be ≥2.
- CNT_W, 32: width of the count buses.

Ports:
- clk_100M, input, 1: system clock, 100 MHz.
- meas_rst, input, 1: asynchronous, active-high reset of this block.
- start, input, 1: single-cycle request to begin one measurement.
- continuous, input, 1: 1 means re-arm automatically after each result handshake.
- meas_gate, input, 1: actual gate from the gate block, same clock domain.
- cnt_s, input, CNT_W: standard count from the gate block.
- cnt_x, input, CNT_W: unknown-signal count from the gate block.
- gate_rst, output, 1: measurement reset to the gate block, active-high.
- busy, output, 1: high in every state except IDLE.
- res_valid, output, 1: result available.
- res_ready, input, 1: consumer accepts the result.
- res_cnt_s, output, CNT_W: captured standard count.
- res_cnt_x, output, CNT_W: captured unknown count.
- res_timeout, output, 1: result is a timeout; both counts are 0.

Behaviour:
- Reset (meas_rst=1, asynchronous):
  - state=IDLE, gate_rst=0, busy=0, res_valid=0.
  - res_cnt_s=0, res_cnt_x=0, res_timeout=0.
  - Timer and the meas_gate_d history register cleared.
- meas_gate_d is the registered copy of meas_gate.
  - Rise: meas_gate=1 and meas_gate_d=0.
  - Fall: meas_gate=0 and meas_gate_d=1.
- States:
  - IDLE: on start=1, go to ARM and load the pulse counter with RST_CYCLES.
  - ARM: gate_rst=1 for exactly RST_CYCLES cycles, starting the cycle after start is sampled. Then go to WAIT_OPEN and clear the timer.
  - WAIT_OPEN: timer increments every cycle. Rise goes to MEASURE. The timer is not cleared on Rise.
  - MEASURE: timer keeps incrementing. Fall goes to PRESENT.
    - The gate block updates cnt_s/cnt_x on the same edge that it drops meas_gate. Therefore, in the Fall cycle, res_cnt_s<=cnt_s, res_cnt_x<=cnt_x, res_timeout<=0 and res_valid<=1.
    - Latency is one cycle from Fall to res_valid.
  - Timeout (WAIT_OPEN or MEASURE): when the timer reaches TIMEOUT_CYCLES-1 and no Fall occurs that cycle:
    - res_cnt_s<=0, res_cnt_x<=0, res_timeout<=1, res_valid<=1.
    - gate_rst is pulsed for RST_CYCLES to abort the gate; this overlaps PRESENT.
    - Go to PRESENT.
    - If Fall and the timeout cycle coincide, Fall wins.
  - PRESENT: res_valid and the result fields are held stable until res_valid&res_ready.
    - On handshake, res_valid<=0.
    - If continuous=1, go to ARM and reload the pulse counter. Otherwise go to IDLE.
- A result is delivered exactly once. With res_ready held high, res_valid is high for exactly 1 cycle.
- start is ignored outside IDLE. It is not queued.
- A continuous change takes effect only at the next PRESENT handshake.
- Rise while in MEASURE, or Fall while in WAIT_OPEN, is ignored.
- meas_rst mid-measurement: immediate return to IDLE; any pending result is discarded.
- The timer is CNT_W bits, saturating, and compared with TIMEOUT_CYCLES-1. It never wraps.

Decomposition:
- Shared package freq_meas_pkg holds:
  - the state enum (IDLE, ARM, WAIT_OPEN, MEASURE, PRESENT);
  - CNT_W;
  - the default TIMEOUT_CYCLES and RST_CYCLES constants, shared with the gate and calculator blocks.
- No sub-module. The timer and the pulse counter are inline counters.

Test Plan:
- Normal single shot, using a behavioural gate model:
  - Stimulus: start; the model raises meas_gate 20 cycles after gate_rst falls, drops it 1000 cycles later with cnt_s=1000, cnt_x=10; res_ready held high.
  - Response: gate_rst high for exactly 4 cycles; res_valid high for 1 cycle, starting 1 cycle after the fall; res_cnt_s=1000, res_cnt_x=10, res_timeout=0; busy low the next cycle.
- Timeout, with TIMEOUT_CYCLES=2000 and meas_gate never rising:
  - Response: res_valid exactly 2000 cycles after WAIT_OPEN entry, with counts 0 and res_timeout=1; gate_rst pulses for 4 cycles.
- Backpressure:
  - Stimulus: res_ready=0 for 50 cycles after res_valid.
  - Response: res_valid and the result fields stay stable; a start pulsed during PRESENT is ignored; one handshake occurs when res_ready=1.
- Continuous mode:
  - Stimulus: continuous=1 and three gate-model measurements (cnt_s 1000/1001/999).
  - Response: three results in order, each followed by a gate_rst pulse starting the cycle after the handshake.
- Fall coincides with the timeout cycle:
  - Response: a real result is delivered with res_timeout=0.
- meas_rst asserted mid-MEASURE:
  - Response: immediate IDLE with all outputs 0; no result is emitted after release.

Source files
------------

// File: rtl/freq_meas_pkg.sv
// Shared definitions for the frequency measurement blocks: sequencer state
// encoding, count bus width and the default gate timing constants.
package freq_meas_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ARM,
      WAIT_OPEN,
      MEASURE,
      PRESENT
   } meas_state_t;

   // Width of the standard/unknown count buses and of the timeout timer.
   localparam int unsigned CNT_W = 32;

   // 3 s at 100 MHz: longest time allowed from arm release to gate close.
   localparam int unsigned DEF_TIMEOUT_CYCLES = 300_000_000;

   // Width of the measurement reset pulse sent to the gate block.
   localparam int unsigned DEF_RST_CYCLES = 4;

endpackage : freq_meas_pkg

// File: rtl/freq_meas_ctrl.sv
// Measurement sequencer for the equal-precision frequency gate: pulses the
// gate reset, waits for the gate to open and close, captures both counts on
// the closing edge (or reports a timeout) and hands the result downstream on
// a valid/ready interface. Optionally re-arms after every delivered result.
module freq_meas_ctrl #(
   parameter int unsigned RST_CYCLES     = freq_meas_pkg::DEF_RST_CYCLES,
   parameter int unsigned TIMEOUT_CYCLES = freq_meas_pkg::DEF_TIMEOUT_CYCLES,
   parameter int unsigned CNT_W          = freq_meas_pkg::CNT_W
) (
   input  logic             clk_100M,
   input  logic             meas_rst,
   input  logic             start,
   input  logic             continuous,
   input  logic             meas_gate,
   input  logic [CNT_W-1:0] cnt_s,
   input  logic [CNT_W-1:0] cnt_x,
   output logic             gate_rst,
   output logic             busy,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [CNT_W-1:0] res_cnt_s,
   output logic [CNT_W-1:0] res_cnt_x,
   output logic             res_timeout
);
   import freq_meas_pkg::*;

   localparam int unsigned      PC_W    = $clog2(RST_CYCLES + 1);
   localparam logic [PC_W-1:0]  PC_LOAD = PC_W'(RST_CYCLES);
   localparam logic [PC_W-1:0]  PC_ONE  = PC_W'(1);
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   meas_state_t      state;
   meas_state_t      state_nxt;
   logic [CNT_W-1:0] timer;
   logic [PC_W-1:0]  pulse_cnt;
   logic             meas_gate_d;

   logic             gate_rise;
   logic             gate_fall;
   logic             timeout_hit;
   logic             handshake;
   logic             pulse_load;
   logic             timer_clr;
   logic             cap_meas;
   logic             cap_to;

   assign gate_rise   = meas_gate & ~meas_gate_d;
   assign gate_fall   = ~meas_gate & meas_gate_d;
   // >= rather than == so a late arrival in MEASURE still times out.
   assign timeout_hit = (timer >= TO_LAST);
   assign handshake   = res_valid & res_ready;

   // The gate reset pulse is the pulse counter being non-zero; it serves
   // both the ARM phase and the abort pulse that overlaps PRESENT.
   assign gate_rst    = (pulse_cnt != '0);
   assign busy        = (state != IDLE);

   // State register.
   always_ff @(posedge clk_100M or posedge meas_rst) begin
      if (meas_rst) state <= IDLE;
      else          state <= state_nxt;
   end

   // Next-state decode and per-cycle control strobes.
   always_comb begin
      state_nxt  = state;
      pulse_load = 1'b0;
      timer_clr  = 1'b0;
      cap_meas   = 1'b0;
      cap_to     = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_nxt  = ARM;
               pulse_load = 1'b1;
            end
         end
         ARM: begin
            if (pulse_cnt <= PC_ONE) begin
               state_nxt = WAIT_OPEN;
               timer_clr = 1'b1;
            end
         end
         WAIT_OPEN: begin
            if (timeout_hit) begin
               state_nxt  = PRESENT;
               cap_to     = 1'b1;
               pulse_load = 1'b1;
            end else if (gate_rise) begin
               state_nxt = MEASURE;
            end
         end
         MEASURE: begin
            // A real close takes priority over a coincident timeout.
            if (gate_fall) begin
               state_nxt = PRESENT;
               cap_meas  = 1'b1;
            end else if (timeout_hit) begin
               state_nxt  = PRESENT;
               cap_to     = 1'b1;
               pulse_load = 1'b1;
            end
         end
         PRESENT: begin
            if (handshake) begin
               if (continuous) begin
                  state_nxt  = ARM;
                  pulse_load = 1'b1;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Gate history for edge detection.
   always_ff @(posedge clk_100M or posedge meas_rst) begin
      if (meas_rst) meas_gate_d <= 1'b0;
      else          meas_gate_d <= meas_gate;
   end

   // Gate reset pulse counter: loaded on arm/abort, counts down to zero.
   always_ff @(posedge clk_100M or posedge meas_rst) begin
      if (meas_rst)              pulse_cnt <= '0;
      else if (pulse_load)       pulse_cnt <= PC_LOAD;
      else if (pulse_cnt != '0)  pulse_cnt <= pulse_cnt - PC_ONE;
   end

   // Saturating timeout timer, running from arm release until gate close.
   always_ff @(posedge clk_100M or posedge meas_rst) begin
      if (meas_rst) begin
         timer <= '0;
      end else if (timer_clr) begin
         timer <= '0;
      end else if ((state == WAIT_OPEN || state == MEASURE) && timer != '1) begin
         timer <= timer + CNT_W'(1);
      end
   end

   // Result capture and valid flag; fields hold until the next capture.
   always_ff @(posedge clk_100M or posedge meas_rst) begin
      if (meas_rst) begin
         res_valid   <= 1'b0;
         res_cnt_s   <= '0;
         res_cnt_x   <= '0;
         res_timeout <= 1'b0;
      end else if (cap_meas) begin
         res_valid   <= 1'b1;
         res_cnt_s   <= cnt_s;
         res_cnt_x   <= cnt_x;
         res_timeout <= 1'b0;
      end else if (cap_to) begin
         res_valid   <= 1'b1;
         res_cnt_s   <= '0;
         res_cnt_x   <= '0;
         res_timeout <= 1'b1;
      end else if (handshake) begin
         res_valid   <= 1'b0;
      end
   end

endmodule : freq_meas_ctrl

// File: tb/tb_freq_meas_ctrl.sv
// Directed bench for freq_meas_ctrl with a behavioural gate model; the
// timeout is shortened to 2000 cycles so the abort path is reachable.
module tb_freq_meas_ctrl;

   localparam int unsigned W = 32;

   logic          clk_100M;
   logic          meas_rst;
   logic          start;
   logic          continuous;
   logic          meas_gate;
   logic [W-1:0]  cnt_s;
   logic [W-1:0]  cnt_x;
   logic          gate_rst;
   logic          busy;
   logic          res_valid;
   logic          res_ready;
   logic [W-1:0]  res_cnt_s;
   logic [W-1:0]  res_cnt_x;
   logic          res_timeout;

   int n_tests = 0;
   int n_fail  = 0;

   freq_meas_ctrl #(
      .RST_CYCLES     (4),
      .TIMEOUT_CYCLES (2000),
      .CNT_W          (W)
   ) dut (
      .clk_100M    (clk_100M),
      .meas_rst    (meas_rst),
      .start       (start),
      .continuous  (continuous),
      .meas_gate   (meas_gate),
      .cnt_s       (cnt_s),
      .cnt_x       (cnt_x),
      .gate_rst    (gate_rst),
      .busy        (busy),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_cnt_s   (res_cnt_s),
      .res_cnt_x   (res_cnt_x),
      .res_timeout (res_timeout)
   );

   // 100 MHz clock.
   initial begin
      clk_100M = 1'b0;
      forever #5 clk_100M = ~clk_100M;
   end

   // Absolute run-time bound.
   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task tick;
      @(posedge clk_100M);
      #1;
   endtask

   // Gate model: count the arm pulse, open 20 cycles after it ends, stay
   // open for open_len cycles, then close with the counts on the same edge.
   task automatic gate_run(input logic [31:0] cs, input logic [31:0] cx,
                           input int open_len, output int glen, output int early);
      glen  = 0;
      early = 0;
      while (gate_rst === 1'b1 && glen < 100) begin
         glen++;
         tick();
      end
      repeat (20) begin
         tick();
         if (res_valid) early++;
      end
      meas_gate = 1'b1;
      repeat (open_len) begin
         tick();
         if (res_valid) early++;
      end
      cnt_s     = cs;
      cnt_x     = cx;
      meas_gate = 1'b0;
      tick();
   endtask

   int glen;
   int early;
   int n;
   int bad;
   logic [31:0] cvals [3];

   initial begin
      meas_rst   = 1'b1;
      start      = 1'b0;
      continuous = 1'b0;
      meas_gate  = 1'b0;
      cnt_s      = '0;
      cnt_x      = '0;
      res_ready  = 1'b1;
      cvals[0]   = 1000;
      cvals[1]   = 1001;
      cvals[2]   = 999;

      // Reset state
      #3;
      chk("rst_busy",     32'(busy),        0);
      chk("rst_gate_rst", 32'(gate_rst),    0);
      chk("rst_valid",    32'(res_valid),   0);
      chk("rst_cnt_s",    res_cnt_s,        0);
      chk("rst_cnt_x",    res_cnt_x,        0);
      chk("rst_timeout",  32'(res_timeout), 0);
      repeat (3) tick();
      meas_rst = 1'b0;
      repeat (2) tick();

      // Normal single shot
      start = 1'b1; tick(); start = 1'b0;
      chk("t1_busy", 32'(busy), 1);
      gate_run(1000, 10, 1000, glen, early);
      chk("t1_glen",    glen, 4);
      chk("t1_early",   early, 0);
      chk("t1_valid",   32'(res_valid), 1);
      chk("t1_cnt_s",   res_cnt_s, 1000);
      chk("t1_cnt_x",   res_cnt_x, 10);
      chk("t1_timeout", 32'(res_timeout), 0);
      tick();
      chk("t1_valid_1cyc", 32'(res_valid), 0);
      chk("t1_busy_after", 32'(busy), 0);

      // Timeout: gate never opens
      start = 1'b1; tick(); start = 1'b0;
      glen = 0;
      while (gate_rst === 1'b1 && glen < 100) begin glen++; tick(); end
      chk("t2_arm_glen", glen, 4);
      n = 0;
      while (res_valid !== 1'b1 && n < 3000) begin tick(); n++; end
      chk("t2_latency",  n, 2000);
      chk("t2_cnt_s",    res_cnt_s, 0);
      chk("t2_cnt_x",    res_cnt_x, 0);
      chk("t2_timeout",  32'(res_timeout), 1);
      chk("t2_abort_on", 32'(gate_rst), 1);
      tick();
      chk("t2_valid_1cyc", 32'(res_valid), 0);
      glen = 1;
      while (gate_rst === 1'b1 && glen < 100) begin glen++; tick(); end
      chk("t2_abort_glen", glen, 4);
      chk("t2_busy_after", 32'(busy), 0);

      // Backpressure, with an ignored start during PRESENT
      res_ready = 1'b0;
      start = 1'b1; tick(); start = 1'b0;
      gate_run(1234, 56, 500, glen, early);
      chk("t3_valid", 32'(res_valid), 1);
      bad = 0;
      for (int i = 0; i < 50; i++) begin
         if (i == 10) start = 1'b1;
         tick();
         start = 1'b0;
         if (res_valid !== 1'b1 || res_cnt_s !== 1234 || res_cnt_x !== 56 ||
             res_timeout !== 1'b0 || gate_rst !== 1'b0) bad++;
      end
      chk("t3_stable", bad, 0);
      res_ready = 1'b1;
      tick();
      chk("t3_valid_off", 32'(res_valid), 0);
      chk("t3_busy_off",  32'(busy), 0);
      chk("t3_no_rearm",  32'(gate_rst), 0);

      // Continuous: three results, last one switches back to single shot
      continuous = 1'b1;
      start = 1'b1; tick(); start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         if (k == 2) continuous = 1'b0;
         gate_run(cvals[k], 32'(20 + k), 800, glen, early);
         chk("t4_glen",  glen, 4);
         chk("t4_early", early, 0);
         chk("t4_valid", 32'(res_valid), 1);
         chk("t4_cnt_s", res_cnt_s, cvals[k]);
         chk("t4_cnt_x", res_cnt_x, 32'(20 + k));
         tick();
         chk("t4_valid_off", 32'(res_valid), 0);
         if (k < 2) begin
            chk("t4_rearm_pulse", 32'(gate_rst), 1);
            chk("t4_rearm_busy",  32'(busy), 1);
         end else begin
            chk("t4_final_pulse", 32'(gate_rst), 0);
            chk("t4_final_busy",  32'(busy), 0);
         end
      end

      // Fall lands on the timeout cycle: real result wins
      start = 1'b1; tick(); start = 1'b0;
      glen = 0;
      while (gate_rst === 1'b1 && glen < 100) begin glen++; tick(); end
      chk("t5_glen", glen, 4);
      repeat (10) tick();
      meas_gate = 1'b1;
      repeat (1989) tick();
      cnt_s     = 777;
      cnt_x     = 7;
      meas_gate = 1'b0;
      tick();
      chk("t5_valid",   32'(res_valid), 1);
      chk("t5_timeout", 32'(res_timeout), 0);
      chk("t5_cnt_s",   res_cnt_s, 777);
      chk("t5_cnt_x",   res_cnt_x, 7);
      tick();
      chk("t5_busy_after", 32'(busy), 0);

      // Reset mid-MEASURE
      start = 1'b1; tick(); start = 1'b0;
      glen = 0;
      while (gate_rst === 1'b1 && glen < 100) begin glen++; tick(); end
      repeat (20) tick();
      meas_gate = 1'b1;
      repeat (100) tick();
      chk("t6_busy_pre", 32'(busy), 1);
      #2 meas_rst = 1'b1;
      #1;
      chk("t6_busy",     32'(busy),        0);
      chk("t6_gate_rst", 32'(gate_rst),    0);
      chk("t6_valid",    32'(res_valid),   0);
      chk("t6_cnt_s",    res_cnt_s,        0);
      chk("t6_cnt_x",    res_cnt_x,        0);
      chk("t6_timeout",  32'(res_timeout), 0);
      meas_gate = 1'b0;
      cnt_s     = 5;
      tick();
      tick();
      meas_rst = 1'b0;
      n = 0;
      repeat (200) begin
         tick();
         if (res_valid) n++;
      end
      chk("t6_no_result", n, 0);
      chk("t6_idle",      32'(busy), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_freq_meas_ctrl
